bas_wr_arbiter: RTL and testbench
=================================

// Module: bas_wr_arbiter
// PURPOSE
//  Shares the single PCIe BAS Avalon-MM write master among NB_REQ write requesters
//  (packet DMA, descriptor DMA, future head write-back engines), one burst at a time.
//  Grants whole bursts in round-robin order and locks the grant until the last beat.
//  Sits between the fpga_to_cpu-style engines and the pcie_bas_* ports in pcie_top.
// PARAMETERS
//  NB_REQ     2    number of requesters (>=1)
//  DWIDTH     512  write data width (bits)
//  BCWIDTH    4    burstcount width; legal burstcount is 1..2**(BCWIDTH-1)
// PORTS
//  pcie_clk             in   1              clock
//  pcie_reset_n         in   1              async reset, active low
//  req_address[NB_REQ]  in   64             per-requester byte address (first beat)
//  req_write[NB_REQ]    in   1              per-requester write strobe
//  req_writedata[NB_REQ] in  DWIDTH         per-requester write data
//  req_byteenable[NB_REQ] in DWIDTH/8       per-requester byte enables
//  req_burstcount[NB_REQ] in BCWIDTH        burst length (first beat)
//  req_waitrequest[NB_REQ] out 1            per-requester backpressure
//  pcie_bas_waitrequest in   1              BAS backpressure
//  pcie_bas_address     out  64             BAS address
//  pcie_bas_write       out  1              BAS write
//  pcie_bas_writedata   out  DWIDTH         BAS data
//  pcie_bas_byteenable  out  DWIDTH/8       BAS byte enables
//  pcie_bas_burstcount  out  BCWIDTH        BAS burstcount
//  grant_id             out  $clog2(NB_REQ) current/last granted requester (1 bit if NB_REQ=1)
//  contention_cnt       out  32             saturating count of cycles a requester waited while another held the grant
// BEHAVIOUR
//  Reset (async, pcie_reset_n=0): state=IDLE, pcie_bas_write=0, all req_waitrequest=1.
//   grant_id=0, rr pointer=NB_REQ-1 (requester 0 wins first), beats_left=0, contention_cnt=0.
//   Reset mid-burst aborts the burst silently; no completion of remaining beats.
//  FSM IDLE:
//   all req_waitrequest=1, pcie_bas_write=0.
//   If any req_write: register grant_id = first requesting index after rr pointer (wrapping).
//   Then load beats_left = req_burstcount of winner (0 is treated as 1) and go to BURST next cycle.
//  FSM BURST:
//   pcie_bas_* = combinational mux of the granted requester's signals.
//   req_waitrequest[grant_id] = pcie_bas_waitrequest; all others = 1.
//   Beat accepted when pcie_bas_write && !pcie_bas_waitrequest; beats_left decrements.
//   Granted requester deasserting write mid-burst: grant stays locked, pcie_bas_write=0, no beat counted.
//   Last beat accepted (beats_left==1): rr pointer=grant_id, go to IDLE. One dead cycle between bursts.
//  Burst address/burstcount: the requester holds them constant for the whole burst (Avalon rule).
//   The arbiter forwards them unchanged and does not re-sample them after the first beat.
//  Fairness: a continuously requesting requester is granted within NB_REQ bursts.
//  contention_cnt: +1 per cycle in BURST when any non-granted req_write=1.
//   +1 per cycle in IDLE when >1 req_write=1. Saturates at 32'hFFFF_FFFF.
//  NB_REQ=1: degenerates to a pass-through with the 1-cycle IDLE gap; contention_cnt stays 0.
//  Latency: first beat reaches BAS 1 cycle after request (IDLE->BURST); later beats are zero-latency.
// TESTING
//  1. Reset, req0 burst of 4, no waitrequest -> BAS sees 4 beats on cycles 1-4, req_waitrequest[0]=0 during them, back to IDLE.
//  2. req0 and req1 both request burst 2 at the same cycle -> req0 served first, then req1.
//     Then req0 again: grants alternate 0,1,0; contention_cnt >= 2.
//  3. pcie_bas_waitrequest=1 for 3 cycles mid-burst -> beat held stable, no duplicate or lost beats, 4 beats total.
//  4. req1 drops write for 2 cycles inside a burst of 3 -> req0 stays blocked.
//     pcie_bas_write=0 in the gap; burst completes with 3 beats.
//  5. Assert pcie_reset_n=0 after 2 of 4 beats -> pcie_bas_write=0 immediately.
//     After release, req0 wins first and a fresh burst proceeds normally.
//  6. burstcount=0 on req0 -> treated as a single beat; returns to IDLE after 1 accepted beat.

Source files
------------

// File: rtl/bas_wr_arbiter.sv
// Round-robin burst arbiter sharing the PCIe BAS Avalon-MM write master among
// NB_REQ write requesters; a grant is locked from the first to the last beat.
module bas_wr_arbiter #(
  parameter int  NB_REQ  = 2,
  parameter int  DWIDTH  = 512,
  parameter int  BCWIDTH = 4,
  localparam int GW      = (NB_REQ > 1) ? $clog2(NB_REQ) : 1,
  localparam int BEW     = DWIDTH / 8
) (
  input  logic               pcie_clk,
  input  logic               pcie_reset_n,
  input  logic [63:0]        req_address     [NB_REQ],
  input  logic               req_write       [NB_REQ],
  input  logic [DWIDTH-1:0]  req_writedata   [NB_REQ],
  input  logic [BEW-1:0]     req_byteenable  [NB_REQ],
  input  logic [BCWIDTH-1:0] req_burstcount  [NB_REQ],
  output logic               req_waitrequest [NB_REQ],
  input  logic               pcie_bas_waitrequest,
  output logic [63:0]        pcie_bas_address,
  output logic               pcie_bas_write,
  output logic [DWIDTH-1:0]  pcie_bas_writedata,
  output logic [BEW-1:0]     pcie_bas_byteenable,
  output logic [BCWIDTH-1:0] pcie_bas_burstcount,
  output logic [GW-1:0]      grant_id,
  output logic [31:0]        contention_cnt
);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t             state, state_next;
  logic [GW-1:0]      rr_ptr;
  logic [GW-1:0]      winner;
  logic [GW-1:0]      cand;
  logic               any_req;
  logic               multi_req;
  logic               others_req;
  logic               seen_req;
  logic [BCWIDTH-1:0] beats_left;
  logic               beat_acc;
  logic               last_beat;
  logic               count_en;

  // Scan from farthest to nearest offset so the first requester after rr_ptr wins.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    winner  = rr_ptr;
    any_req = 1'b0;
    cand    = '0;
    for (int off = NB_REQ; off >= 1; off--) begin
      cand = GW'((int'(rr_ptr) + off) % NB_REQ);
      if (req_write[cand]) begin
        winner  = cand;
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    multi_req  = 1'b0;
    others_req = 1'b0;
    seen_req   = 1'b0;
    for (int i = 0; i < NB_REQ; i++) begin
      if (req_write[i]) begin
        if (seen_req) multi_req = 1'b1;
        seen_req = 1'b1;
        if (GW'(i) != grant_id) others_req = 1'b1;
      end
    end
  end

  // Data path is a plain mux of the granted requester; only the write strobe is gated.
  assign pcie_bas_address    = req_address[grant_id];
  assign pcie_bas_writedata  = req_writedata[grant_id];
  assign pcie_bas_byteenable = req_byteenable[grant_id];
  assign pcie_bas_burstcount = req_burstcount[grant_id];
  assign pcie_bas_write      = (state == S_BURST) && req_write[grant_id];

  assign beat_acc  = pcie_bas_write && !pcie_bas_waitrequest;
  assign last_beat = beat_acc && (beats_left == BCWIDTH'(1));

  always_comb begin
    for (int i = 0; i < NB_REQ; i++) req_waitrequest[i] = 1'b1;
    if (state == S_BURST) req_waitrequest[grant_id] = pcie_bas_waitrequest;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (any_req)   state_next = S_BURST;
      S_BURST: if (last_beat) state_next = S_IDLE;
      default:                state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge pcie_clk or negedge pcie_reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!pcie_reset_n) state <= S_IDLE;
    else               state <= state_next;
  end

  // A zero burstcount is served as a single beat.
  always_ff @(posedge pcie_clk or negedge pcie_reset_n) begin
    if (!pcie_reset_n) begin
      grant_id   <= '0;
      rr_ptr     <= GW'(NB_REQ - 1);
      beats_left <= '0;
    end else if (state == S_IDLE && any_req) begin
      grant_id   <= winner;
      beats_left <= (req_burstcount[winner] == '0) ? BCWIDTH'(1) : req_burstcount[winner];
    end else if (beat_acc) begin
      beats_left <= beats_left - 1'b1;
      if (last_beat) rr_ptr <= grant_id;
    end
  end

  assign count_en = ((state == S_BURST) && others_req) || ((state == S_IDLE) && multi_req);

  always_ff @(posedge pcie_clk or negedge pcie_reset_n) begin
    if (!pcie_reset_n)                            contention_cnt <= '0;
    else if (count_en && (contention_cnt != '1)) contention_cnt <= contention_cnt + 1'b1;
  end

endmodule

// File: tb/tb_bas_wr_arbiter.sv
// Directed self-checking bench for bas_wr_arbiter with two requesters and a
// narrow data path; every expected value is written out by hand below.
module tb_bas_wr_arbiter;

  localparam int NB_REQ  = 2;
  localparam int DWIDTH  = 32;
  localparam int BCWIDTH = 4;
  localparam int BEW     = DWIDTH / 8;

  logic               pcie_clk = 1'b0;
  logic               pcie_reset_n = 1'b1;
  logic [63:0]        req_address     [NB_REQ];
  logic               req_write       [NB_REQ];
  logic [DWIDTH-1:0]  req_writedata   [NB_REQ];
  logic [BEW-1:0]     req_byteenable  [NB_REQ];
  logic [BCWIDTH-1:0] req_burstcount  [NB_REQ];
  logic               req_waitrequest [NB_REQ];
  logic               pcie_bas_waitrequest;
  logic [63:0]        pcie_bas_address;
  logic               pcie_bas_write;
  logic [DWIDTH-1:0]  pcie_bas_writedata;
  logic [BEW-1:0]     pcie_bas_byteenable;
  logic [BCWIDTH-1:0] pcie_bas_burstcount;
  logic [0:0]         grant_id;
  logic [31:0]        contention_cnt;

  int n_checks = 0;
  int n_errors = 0;

  bas_wr_arbiter #(.NB_REQ(NB_REQ), .DWIDTH(DWIDTH), .BCWIDTH(BCWIDTH)) dut (
    .pcie_clk             (pcie_clk),
    .pcie_reset_n         (pcie_reset_n),
    .req_address          (req_address),
    .req_write            (req_write),
    .req_writedata        (req_writedata),
    .req_byteenable       (req_byteenable),
    .req_burstcount       (req_burstcount),
    .req_waitrequest      (req_waitrequest),
    .pcie_bas_waitrequest (pcie_bas_waitrequest),
    .pcie_bas_address     (pcie_bas_address),
    .pcie_bas_write       (pcie_bas_write),
    .pcie_bas_writedata   (pcie_bas_writedata),
    .pcie_bas_byteenable  (pcie_bas_byteenable),
    .pcie_bas_burstcount  (pcie_bas_burstcount),
    .grant_id             (grant_id),
    .contention_cnt       (contention_cnt)
  );

  always #5 pcie_clk = ~pcie_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
  task automatic tick();
    @(posedge pcie_clk);
    #1;
  endtask

  task automatic chk_idle(input string tag, input logic [31:0] exp_cnt);
    #1;
    check({tag, "/write"}, pcie_bas_write, 1'b0);
    check({tag, "/wait0"}, req_waitrequest[0], 1'b1);
    check({tag, "/wait1"}, req_waitrequest[1], 1'b1);
    check({tag, "/cnt"}, contention_cnt, exp_cnt);
  endtask

  task automatic chk_beat(input string tag, input int r, input logic [63:0] addr,
                          input logic [DWIDTH-1:0] data, input logic [BEW-1:0] be,
                          input logic [BCWIDTH-1:0] bc, input logic exp_wait);
    int other;
    other = 1 - r;
    req_writedata[r] = data;
    #1;
    check({tag, "/write"}, pcie_bas_write, 1'b1);
    check({tag, "/grant"}, grant_id, r);
    check({tag, "/addr"}, pcie_bas_address, addr);
    check({tag, "/data"}, pcie_bas_writedata, data);
    check({tag, "/be"}, pcie_bas_byteenable, be);
    check({tag, "/bc"}, pcie_bas_burstcount, bc);
    check({tag, "/wait_own"}, req_waitrequest[r], exp_wait);
    check({tag, "/wait_other"}, req_waitrequest[other], 1'b1);
    tick();
  endtask

  task automatic do_reset(input string tag);
    pcie_reset_n = 1'b0;
    #1;
    check({tag, "/write"}, pcie_bas_write, 1'b0);
    check({tag, "/wait0"}, req_waitrequest[0], 1'b1);
    check({tag, "/wait1"}, req_waitrequest[1], 1'b1);
    check({tag, "/grant"}, grant_id, 1'b0);
    check({tag, "/cnt"}, contention_cnt, 32'd0);
    tick();
    pcie_reset_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NB_REQ; i++) begin
      req_address[i]    = '0;
      req_write[i]      = 1'b0;
      req_writedata[i]  = '0;
      req_byteenable[i] = '0;
      req_burstcount[i] = '0;
    end
    pcie_bas_waitrequest = 1'b0;
    #2;
    do_reset("rst0");

    // 1: single burst of 4 from requester 0
    req_write[0] = 1'b1; req_address[0] = 64'h1000; req_burstcount[0] = 4'd4; req_byteenable[0] = 4'hF;
    chk_idle("t1_idle", 32'd0);
    tick();
    for (int b = 0; b < 4; b++)
      chk_beat($sformatf("t1_beat%0d", b), 0, 64'h1000, 32'hA100_0000 + b, 4'hF, 4'd4, 1'b0);
    req_write[0] = 1'b0;
    chk_idle("t1_end", 32'd0);

    // 2: simultaneous requests, then alternation 0,1,0
    do_reset("rst1");
    req_write[0] = 1'b1; req_address[0] = 64'h2000; req_burstcount[0] = 4'd2; req_byteenable[0] = 4'h3;
    req_write[1] = 1'b1; req_address[1] = 64'h3000; req_burstcount[1] = 4'd2; req_byteenable[1] = 4'hC;
    chk_idle("t2_idle0", 32'd0);
    tick();
    chk_beat("t2_g0a", 0, 64'h2000, 32'hB200_0000, 4'h3, 4'd2, 1'b0);
    chk_beat("t2_g0b", 0, 64'h2000, 32'hB200_0001, 4'h3, 4'd2, 1'b0);
    req_write[0] = 1'b0;
    chk_idle("t2_idle1", 32'd3);
    tick();
    req_write[0] = 1'b1; req_address[0] = 64'h2100;
    chk_beat("t2_g1a", 1, 64'h3000, 32'hC300_0000, 4'hC, 4'd2, 1'b0);
    chk_beat("t2_g1b", 1, 64'h3000, 32'hC300_0001, 4'hC, 4'd2, 1'b0);
    req_write[1] = 1'b0;
    chk_idle("t2_idle2", 32'd5);
    tick();
    chk_beat("t2_g2a", 0, 64'h2100, 32'hB210_0000, 4'h3, 4'd2, 1'b0);
    chk_beat("t2_g2b", 0, 64'h2100, 32'hB210_0001, 4'h3, 4'd2, 1'b0);
    req_write[0] = 1'b0;
    chk_idle("t2_end", 32'd5);

    // 3: BAS backpressure for 3 cycles on the third beat
    req_write[0] = 1'b1; req_address[0] = 64'h4000; req_burstcount[0] = 4'd4; req_byteenable[0] = 4'hF;
    chk_idle("t3_idle", 32'd5);
    tick();
    chk_beat("t3_b0", 0, 64'h4000, 32'hD400_0000, 4'hF, 4'd4, 1'b0);
    chk_beat("t3_b1", 0, 64'h4000, 32'hD400_0001, 4'hF, 4'd4, 1'b0);
    pcie_bas_waitrequest = 1'b1;
    for (int i = 0; i < 3; i++)
      chk_beat($sformatf("t3_hold%0d", i), 0, 64'h4000, 32'hD400_0002, 4'hF, 4'd4, 1'b1);
    pcie_bas_waitrequest = 1'b0;
    chk_beat("t3_b2", 0, 64'h4000, 32'hD400_0002, 4'hF, 4'd4, 1'b0);
    chk_beat("t3_b3", 0, 64'h4000, 32'hD400_0003, 4'hF, 4'd4, 1'b0);
    req_write[0] = 1'b0;
    chk_idle("t3_end", 32'd5);

    // 4: requester 1 pauses mid-burst, requester 0 stays blocked
    req_write[1] = 1'b1; req_address[1] = 64'h5000; req_burstcount[1] = 4'd3; req_byteenable[1] = 4'h5;
    req_write[0] = 1'b1; req_address[0] = 64'h6000; req_burstcount[0] = 4'd1; req_byteenable[0] = 4'hA;
    chk_idle("t4_idle0", 32'd5);
    tick();
    chk_beat("t4_b0", 1, 64'h5000, 32'hE500_0000, 4'h5, 4'd3, 1'b0);
    req_write[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check($sformatf("t4_gap%0d/write", i), pcie_bas_write, 1'b0);
      check($sformatf("t4_gap%0d/grant", i), grant_id, 1'b1);
      check($sformatf("t4_gap%0d/wait0", i), req_waitrequest[0], 1'b1);
      check($sformatf("t4_gap%0d/wait1", i), req_waitrequest[1], 1'b0);
      tick();
    end
    req_write[1] = 1'b1;
    chk_beat("t4_b1", 1, 64'h5000, 32'hE500_0001, 4'h5, 4'd3, 1'b0);
    chk_beat("t4_b2", 1, 64'h5000, 32'hE500_0002, 4'h5, 4'd3, 1'b0);
    req_write[1] = 1'b0;
    chk_idle("t4_idle1", 32'd11);
    tick();
    chk_beat("t4_r0", 0, 64'h6000, 32'hF600_0000, 4'hA, 4'd1, 1'b0);
    req_write[0] = 1'b0;
    chk_idle("t4_end", 32'd11);

    // 5: reset after 2 of 4 beats, then a fresh arbitration round
    req_write[0] = 1'b1; req_address[0] = 64'h7000; req_burstcount[0] = 4'd4; req_byteenable[0] = 4'hF;
    chk_idle("t5_idle0", 32'd11);
    tick();
    chk_beat("t5_b0", 0, 64'h7000, 32'h1700_0000, 4'hF, 4'd4, 1'b0);
    chk_beat("t5_b1", 0, 64'h7000, 32'h1700_0001, 4'hF, 4'd4, 1'b0);
    req_address[0] = 64'h8000; req_burstcount[0] = 4'd2;
    req_write[1] = 1'b1; req_address[1] = 64'h9000; req_burstcount[1] = 4'd1; req_byteenable[1] = 4'h6;
    do_reset("t5_rst");
    chk_idle("t5_idle1", 32'd0);
    tick();
    chk_beat("t5_g0a", 0, 64'h8000, 32'h2800_0000, 4'hF, 4'd2, 1'b0);
    chk_beat("t5_g0b", 0, 64'h8000, 32'h2800_0001, 4'hF, 4'd2, 1'b0);
    req_write[0] = 1'b0;
    chk_idle("t5_idle2", 32'd3);
    tick();
    chk_beat("t5_r1", 1, 64'h9000, 32'h3900_0000, 4'h6, 4'd1, 1'b0);
    req_write[1] = 1'b0;
    chk_idle("t5_end", 32'd3);

    // 6: burstcount of zero is served as one beat; write held high to expose the idle gap
    req_write[0] = 1'b1; req_address[0] = 64'hA000; req_burstcount[0] = 4'd0; req_byteenable[0] = 4'hF;
    chk_idle("t6_idle", 32'd3);
    tick();
    chk_beat("t6_b0", 0, 64'hA000, 32'h4A00_0000, 4'hF, 4'd0, 1'b0);
    chk_idle("t6_end", 32'd3);
    req_write[0] = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
